// File: rtl/gf_mixcol_sched.sv
// Area-optimised AES MixColumns (forward) for one column: a single shared
// GF(2^8) adder and xtime unit stepped through 16 byte operations.
module gf_mixcol_sched #(
  parameter logic [7:0] RED_POLY = 8'h1b
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] col_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] col_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  acc_q, acc_d;
  logic [31:0] col_q, col_d;
  logic [31:0] res_q, res_d;

  logic [1:0]  opnd_idx;
  logic [7:0]  add_a, add_b, add_sum;
  logic        last_op;

  // Row k lives in byte [31-8k -: 8]; a0 is the most significant byte.
  function automatic logic [7:0] col_byte(input logic [31:0] c, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = c[31:24];
      2'd1:    b = c[23:16];
      2'd2:    b = c[15:8];
      default: b = c[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RED_POLY : 8'h00);
  endfunction

  // Step 0 adds a_r and a_{r+1}; steps 1..3 add acc and a_{r+step} (mod 4).
  assign opnd_idx = row_q + ((step_q == 2'd0) ? 2'd1 : step_q);
  assign add_a    = (step_q == 2'd0) ? col_byte(col_q, row_q) : acc_q;
  assign add_b    = col_byte(col_q, opnd_idx);
  assign add_sum  = add_a ^ add_b;
  assign last_op  = (row_q == 2'd3) && (step_q == 2'd3);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid)  state_d = CALC;
        CALC:    if (last_op)   state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      CALC:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign col_out = res_q;

  // Datapath next state
  always_comb begin
    row_d  = row_q;
    step_d = step_q;
    acc_d  = acc_q;
    col_d  = col_q;
    res_d  = res_q;
    if (clear) begin
      row_d  = 2'd0;
      step_d = 2'd0;
      acc_d  = 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            col_d  = col_in;
            row_d  = 2'd0;
            step_d = 2'd0;
          end
        end
        CALC: begin
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) row_d = row_q + 2'd1;
          case (step_q)
            2'd0: acc_d = xtime(add_sum);
            2'd3: begin
              case (row_q)
                2'd0:    res_d[31:24] = add_sum;
                2'd1:    res_d[23:16] = add_sum;
                2'd2:    res_d[15:8]  = add_sum;
                default: res_d[7:0]   = add_sum;
              endcase
            end
            default: acc_d = add_sum;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= 2'd0;
      step_q <= 2'd0;
      acc_q  <= 8'h00;
      col_q  <= 32'h0;
      res_q  <= 32'h0;
    end else begin
      row_q  <= row_d;
      step_q <= step_d;
      acc_q  <= acc_d;
      col_q  <= col_d;
      res_q  <= res_d;
    end
  end

endmodule
